// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 sequential demultiplexer.
package demux_pkg;

   localparam logic        LANE1 = 1'b0;
   localparam logic        LANE2 = 1'b1;
   localparam int unsigned CNT_W = 8;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage : demux_pkg

// File: rtl/demux_lane_buf.sv
// One output lane: 1-entry data buffer, valid flag, ready term and handshake counter.
module demux_lane_buf
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             rdy,
   output logic [WIDTH-1:0] data,
   output logic             vld,
   output logic             can_take,
   output cnt_t             cnt
);

   logic drain;

   assign drain    = vld & rdy;
   // A full buffer can still take a beat when it drains in the same cycle.
   assign can_take = ~vld | rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         vld  <= 1'b0;
         cnt  <= '0;
      end else begin
         if (drain) begin
            cnt <= cnt + cnt_t'(1);
         end
         if (load) begin
            data <= din;
            vld  <= 1'b1;
         end else if (drain) begin
            vld  <= 1'b0;
         end
      end
   end

endmodule : demux_lane_buf

// File: rtl/demux_1x2_seq.sv
// 1-to-2 demultiplexer with per-lane buffering; lane chosen by in_s or by an
// alternating toggle, with independent downstream handshakes per lane.
module demux_1x2_seq
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic [WIDTH-1:0] in_x,
   input  logic             in_valid,
   output logic             out_ready,
   input  logic             in_s,
   input  logic             in_mode,
   output logic [WIDTH-1:0] out_f1,
   output logic [WIDTH-1:0] out_f2,
   output logic             out_v1,
   output logic             out_v2,
   input  logic             in_r1,
   input  logic             in_r2,
   output cnt_t             out_cnt1,
   output cnt_t             out_cnt2
);

   logic alt;
   logic sel;
   logic accept;
   logic take1;
   logic take2;

   assign sel       = in_mode ? alt : in_s;
   assign out_ready = (sel == LANE2) ? take2 : take1;
   assign accept    = in_valid & out_ready;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         alt <= LANE1;
      end else if (accept && in_mode) begin
         alt <= ~alt;
      end
   end

   demux_lane_buf #(.WIDTH(WIDTH)) u_lane1 (
      .clk      (in_clk),
      .rst_n    (in_rst_n),
      .load     (accept && (sel == LANE1)),
      .din      (in_x),
      .rdy      (in_r1),
      .data     (out_f1),
      .vld      (out_v1),
      .can_take (take1),
      .cnt      (out_cnt1)
   );

   demux_lane_buf #(.WIDTH(WIDTH)) u_lane2 (
      .clk      (in_clk),
      .rst_n    (in_rst_n),
      .load     (accept && (sel == LANE2)),
      .din      (in_x),
      .rdy      (in_r2),
      .data     (out_f2),
      .vld      (out_v2),
      .can_take (take2),
      .cnt      (out_cnt2)
   );

endmodule : demux_1x2_seq

// File: doc/demux_1x2_seq.md
DEMUX_1X2_SEQ -- requirements
Module: demux_1x2_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 SHALL have port in_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port in_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_x, input, WIDTH bits: upstream data.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-006 SHALL have port out_ready, output, 1 bit: upstream beat accepted when in_valid and out_ready are both 1.
REQ-007 SHALL have port in_s, input, 1 bit: lane select sampled with the beat (0 = lane 1, 1 = lane 2).
REQ-008 SHALL have port in_mode, input, 1 bit: 0 = use in_s; 1 = alternate lanes.
REQ-009 SHALL have ports out_f1 and out_f2, output, WIDTH bits: lane data, registered.
REQ-010 SHALL have ports out_v1 and out_v2, output, 1 bit each: lane data valid.
REQ-011 SHALL have ports in_r1 and in_r2, input, 1 bit each: lane downstream ready.
REQ-012 SHALL have ports out_cnt1 and out_cnt2, output, 8 bits each: count of completed lane handshakes.

Function
REQ-013 SHALL give each lane a 1-entry buffer (data and valid bit); out_fN and out_vN come straight from that buffer.
REQ-014 SHALL form the effective select as sel = in_mode ? alt : in_s, where alt is an internal toggle bit.
REQ-015 SHALL drive out_ready = !out_v[sel] | in_r[sel] combinationally; the non-selected lane has no effect on out_ready.
REQ-016 SHALL, on an accepted beat, load in_x into the selected lane buffer and set its valid bit at the next edge; latency is 1 cycle and no beat is duplicated or dropped.
REQ-017 SHALL complete a lane handshake on any cycle where out_vN and in_rN are both 1; with no reload in that cycle, out_vN clears at the next edge.
REQ-018 SHALL, on a simultaneous drain and reload of the same lane, keep out_vN at 1 and present the new data with no bubble.
REQ-019 SHALL hold out_fN stable while out_vN is 1 and in_rN is 0.
REQ-020 SHALL let lanes drain independently; a stalled lane never blocks beats selected to the other lane.
REQ-021 SHALL toggle alt on each accepted beat only when in_mode is 1; alt holds its value while in_mode is 0.
REQ-022 SHALL increment out_cntN by 1 on each lane-N handshake, wrapping from 255 to 0.
REQ-023 SHALL take in_mode changes effect from the next beat; a beat already in a buffer is unaffected.
REQ-024 SHALL ignore in_x and in_s while in_valid is 0.

Reset
REQ-025 SHALL clear all state asynchronously while in_rst_n is 0: out_v1 = out_v2 = 0, out_f1 = out_f2 = 0, out_cnt1 = out_cnt2 = 0, alt = 0 (lane 1 first).
REQ-026 SHALL discard buffered beats on a reset asserted mid-transfer.
REQ-027 SHALL accept beats from the first rising edge after in_rst_n deasserts; out_ready may be 1 during reset, but no state changes.

Structure
REQ-028 SHALL place the lane-index constants (LANE1 = 0, LANE2 = 1) and the 8-bit counter width in the shared package demux_pkg.
REQ-029 SHALL implement each lane as one instance of sub-module demux_lane_buf, which holds the buffer, valid bit, ready term and counter; the top level holds sel, alt and steering.

Verification
REQ-030 SHALL check: mode 0, in_s = 0, in_x = 8'hA5, both in_rN = 1 -> out_f1 = A5 with out_v1 = 1 one cycle later; out_cnt1 = 1; out_v2 stays 0.
REQ-031 SHALL check: mode 1, four back-to-back beats 1,2,3,4 -> lane 1 receives 1,3 and lane 2 receives 2,4; out_cnt1 = out_cnt2 = 2.
REQ-032 SHALL check: in_r2 = 0, two beats to lane 2 -> first held stable, out_ready = 0 on the second; set in_r2 = 1 -> second delivered, no loss.
REQ-033 SHALL check: lane 2 stalled, beats to lane 1 -> lane 1 traffic flows every cycle.
REQ-034 SHALL check: 256 lane-1 handshakes -> out_cnt1 wraps to 0.
REQ-035 SHALL check: assert in_rst_n = 0 while out_v1 = 1 -> out_v1 = 0 immediately, counters 0, next mode-1 beat goes to lane 1.
